// File: rtl/twiddle_gen_qw_if.sv
// Request/burst/response bundle for twiddle_gen_qw; slave = generator, master = requester/consumer.
// TWIDDLE_IFFT_EN adds the inv request qualifier.
interface twiddle_gen_qw_if #(
    parameter int unsigned TWIDDLE_WIDTH = 64,
    parameter int unsigned LOG2N         = 10
);
    logic                     in_valid;
    logic                     in_ready;
    logic [LOG2N-1:0]         in_k;
    logic                     bst_start;
    logic [LOG2N-1:0]         bst_base;
    logic [LOG2N-1:0]         bst_stride;
    logic [LOG2N:0]           bst_len;
    logic                     busy;
    logic                     out_valid;
    logic                     out_ready;
    logic [TWIDDLE_WIDTH-1:0] twiddle;
`ifdef TWIDDLE_IFFT_EN
    logic                     inv;

    modport slave (
        input  in_valid, in_k, bst_start, bst_base, bst_stride, bst_len, out_ready, inv,
        output in_ready, busy, out_valid, twiddle
    );
    modport master (
        output in_valid, in_k, bst_start, bst_base, bst_stride, bst_len, out_ready, inv,
        input  in_ready, busy, out_valid, twiddle
    );
`else
    modport slave (
        input  in_valid, in_k, bst_start, bst_base, bst_stride, bst_len, out_ready,
        output in_ready, busy, out_valid, twiddle
    );
    modport master (
        output in_valid, in_k, bst_start, bst_base, bst_stride, bst_len, out_ready,
        input  in_ready, busy, out_valid, twiddle
    );
`endif
endinterface

// File: rtl/twiddle_gen_qw.sv
// Twiddle generator W_N^k from a quarter-wave cosine table, 3-stage valid/ready pipeline plus burst FSM.
// Optional conjugate output (inverse transform) enabled by defining TWIDDLE_IFFT_EN.
module twiddle_gen_qw #(
    parameter int unsigned TWIDDLE_WIDTH = 64,
    parameter int unsigned LOG2N         = 10
) (
    input  logic            clk,
    input  logic            rst,
    twiddle_gen_qw_if.slave tw
);
    localparam int unsigned HW = TWIDDLE_WIDTH / 2;
    localparam int unsigned QN = 1 << (LOG2N - 2);
    localparam int unsigned AW = LOG2N - 1;
    localparam int unsigned FB = 60;
    localparam logic signed [127:0] ONE   = 128'sd1 <<< FB;
    localparam logic signed [127:0] PI_Q  = 128'sh3243F6A8885A308D;
    localparam logic signed [127:0] SCALE = (128'sd1 <<< (HW - 1)) - 128'sd1;

    // Table contents are evaluated at elaboration: Taylor series for cos in Q60, rounded to Q1.(HW-1).
    function automatic logic [HW-1:0] cos_word(input int m);
        logic signed [127:0] x, x2, term, sum, den, scaled;
        x    = (PI_Q * 128'(m) * 128'sd2) >>> LOG2N;
        x2   = (x * x) >>> FB;
        term = ONE;
        sum  = ONE;
        for (int unsigned i = 1; i <= 14; i++) begin
            den  = $signed(128'((2 * i - 1) * (2 * i)));
            term = -((term * x2) >>> FB) / den;
            sum  = sum + term;
        end
        scaled = (sum * SCALE + (ONE >>> 1)) >>> FB;
        if (scaled < 0)     scaled = '0;
        if (scaled > SCALE) scaled = SCALE;
        return scaled[HW-1:0];
    endfunction

    logic [HW-1:0] cos_rom [QN+1];
    for (genvar g = 0; g <= QN; g++) begin : g_rom
        localparam logic [HW-1:0] CV = cos_word(g);
        assign cos_rom[g] = CV;
    end

    typedef enum logic {IDLE, BURST} state_t;
    state_t state, state_n;

    logic [LOG2N-1:0] idx, stride;
    logic [LOG2N:0]   cnt;
    logic             inv_b;
    logic             load_bst, step_bst;

    logic             adv, in_ready, inv_in;
    logic             inj_v, inj_i;
    logic [LOG2N-1:0] inj_k;

    logic             v0, v1, i0, i1, out_valid;
    logic [LOG2N-1:0] k0;
    logic [1:0]       q1;
    logic [HW-1:0]    c1, s1, re_n, im_n;
    logic [AW-1:0]    idx_c, idx_s;
    logic [TWIDDLE_WIDTH-1:0] twiddle;

`ifdef TWIDDLE_IFFT_EN
    assign inv_in = tw.inv;
`else
    assign inv_in = 1'b0;
`endif

    assign adv          = !out_valid || tw.out_ready;
    assign in_ready     = adv && (state == IDLE) && !tw.bst_start;
    assign tw.in_ready  = in_ready;
    assign tw.busy      = (state == BURST);
    assign tw.out_valid = out_valid;
    assign tw.twiddle   = twiddle;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n  = state;
        load_bst = 1'b0;
        step_bst = 1'b0;
        case (state)
            IDLE: begin
                if (tw.bst_start && tw.bst_len != '0) begin
                    state_n  = BURST;
                    load_bst = 1'b1;
                end
            end
            default: begin
                if (adv) begin
                    step_bst = 1'b1;
                    if (cnt == {{LOG2N{1'b0}}, 1'b1}) state_n = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= '0;
            stride <= '0;
            cnt    <= '0;
            inv_b  <= 1'b0;
        end else if (load_bst) begin
            idx    <= tw.bst_base;
            stride <= tw.bst_stride;
            cnt    <= tw.bst_len;
            inv_b  <= inv_in;
        end else if (step_bst) begin
            idx <= idx + stride;
            cnt <= cnt - 1'b1;
        end
    end

    always_comb begin
        inj_v = 1'b0;
        inj_k = tw.in_k;
        inj_i = inv_in;
        if (state == BURST) begin
            inj_v = 1'b1;
            inj_k = idx;
            inj_i = inv_b;
        end else if (tw.in_valid && in_ready) begin
            inj_v = 1'b1;
        end
    end

    // Sine comes from the mirrored cosine entry C(N/4 - m).
    assign idx_c = {1'b0, k0[LOG2N-3:0]};
    assign idx_s = AW'(QN) - idx_c;

    always_comb begin
        re_n = c1;
        im_n = -s1;
        case (q1)
            2'd0:    begin re_n = c1;  im_n = -s1; end
            2'd1:    begin re_n = -s1; im_n = -c1; end
            2'd2:    begin re_n = -c1; im_n = s1;  end
            default: begin re_n = s1;  im_n = c1;  end
        endcase
        if (i1) im_n = -im_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v0        <= 1'b0;
            v1        <= 1'b0;
            out_valid <= 1'b0;
            k0        <= '0;
            i0        <= 1'b0;
            i1        <= 1'b0;
            q1        <= '0;
            c1        <= '0;
            s1        <= '0;
            twiddle   <= '0;
        end else if (adv) begin
            v0        <= inj_v;
            k0        <= inj_k;
            i0        <= inj_i;
            v1        <= v0;
            q1        <= k0[LOG2N-1:LOG2N-2];
            c1        <= cos_rom[idx_c];
            s1        <= cos_rom[idx_s];
            i1        <= i0;
            out_valid <= v1;
            twiddle   <= {re_n, im_n};
        end
    end
endmodule

// File: tb/tb_twiddle_gen_qw.sv
// Directed bench for twiddle_gen_qw at 32-bit output, N=1024; expected words are hand-computed Q1.15.
// Define TWIDDLE_IFFT_EN to also exercise the conjugate path.
module tb_twiddle_gen_qw;
    localparam int unsigned TW = 32;
    localparam int unsigned LN = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    twiddle_gen_qw_if #(.TWIDDLE_WIDTH(TW), .LOG2N(LN)) tw_if ();
    twiddle_gen_qw #(.TWIDDLE_WIDTH(TW), .LOG2N(LN)) dut (.clk(clk), .rst(rst), .tw(tw_if));

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned n_out = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard plus hold check on every stalled cycle.
    logic        stalled = 1'b0;
    logic [31:0] held    = '0;
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("stall_valid", 64'(tw_if.out_valid), 64'd1);
                chk("stall_hold", 64'(tw_if.twiddle), 64'(held));
            end
            if (tw_if.out_valid && tw_if.out_ready) begin
                n_out++;
                chk("out_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) chk("out_data", 64'(tw_if.twiddle), 64'(exp_q.pop_front()));
            end
            stalled = tw_if.out_valid && !tw_if.out_ready;
            held    = tw_if.twiddle;
        end
    end

    task automatic send_direct(input logic [9:0] k, input logic [31:0] w, input logic iv);
        tw_if.in_valid = 1'b1;
        tw_if.in_k     = k;
`ifdef TWIDDLE_IFFT_EN
        tw_if.inv      = iv;
`endif
        exp_q.push_back(w);
        @(negedge clk);
        chk("direct_in_ready", 64'(tw_if.in_ready), 64'(iv) | 64'd1);
        @(posedge clk); #1;
        tw_if.in_valid = 1'b0;
    endtask

    task automatic start_burst(input logic [9:0] base, input logic [9:0] stride, input logic [10:0] len);
        tw_if.bst_start  = 1'b1;
        tw_if.bst_base   = base;
        tw_if.bst_stride = stride;
        tw_if.bst_len    = len;
        @(posedge clk); #1;
        tw_if.bst_start  = 1'b0;
    endtask

    task automatic idle_cycles(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [9:0]  t1_k [4] = '{10'd0, 10'd256, 10'd512, 10'd768};
    logic [31:0] t1_w [4] = '{32'h7FFF0000, 32'h00008001, 32'h80010000, 32'h00007FFF};
    logic        t1_ov[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] t4_w [8] = '{32'h7FFF0000, 32'h5A82A57E, 32'h00008001, 32'hA57EA57E,
                              32'h80010000, 32'hA57E5A82, 32'h00007FFF, 32'h5A825A82};
    logic        pat  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        int unsigned n0, busy_cnt, lat, guard;

        tw_if.in_valid   = 1'b0;
        tw_if.in_k       = '0;
        tw_if.bst_start  = 1'b0;
        tw_if.bst_base   = '0;
        tw_if.bst_stride = '0;
        tw_if.bst_len    = '0;
        tw_if.out_ready  = 1'b1;
`ifdef TWIDDLE_IFFT_EN
        tw_if.inv        = 1'b0;
`endif
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(tw_if.out_valid), 64'd0);
        chk("rst_busy", 64'(tw_if.busy), 64'd0);
        chk("rst_twiddle", 64'(tw_if.twiddle), 64'd0);
        chk("rst_in_ready", 64'(tw_if.in_ready), 64'd1);

        // Quadrant axes back-to-back; out_valid timing per cycle.
        @(posedge clk); #1;
        for (int unsigned c = 0; c < 8; c++) begin
            if (c < 4) begin
                tw_if.in_valid = 1'b1;
                tw_if.in_k     = t1_k[c];
                exp_q.push_back(t1_w[c]);
            end else begin
                tw_if.in_valid = 1'b0;
            end
            @(negedge clk);
            chk("t1_out_valid", 64'(tw_if.out_valid), 64'(t1_ov[c]));
            @(posedge clk); #1;
        end

        // Diagonals.
        send_direct(10'd128, 32'h5A82A57E, 1'b0);
        send_direct(10'd384, 32'hA57EA57E, 1'b0);
        send_direct(10'd896, 32'h5A825A82, 1'b0);
        idle_cycles(5);

        // Wrapping burst, with a second start while busy that must be ignored.
        exp_q.push_back(32'h7FF50324);
        exp_q.push_back(32'h7FFD0192);
        exp_q.push_back(32'h7FFF0000);
        exp_q.push_back(32'h7FFDFE6E);
        tw_if.bst_start  = 1'b1;
        tw_if.bst_base   = 10'd1020;
        tw_if.bst_stride = 10'd2;
        tw_if.bst_len    = 11'd4;
        @(negedge clk);
        chk("t3_in_ready_start", 64'(tw_if.in_ready), 64'd0);
        @(posedge clk); #1;
        tw_if.bst_start = 1'b0;
        busy_cnt = 0;
        for (int unsigned c = 0; c < 10; c++) begin
            if (c == 1) begin
                tw_if.bst_start  = 1'b1;
                tw_if.bst_base   = 10'd0;
                tw_if.bst_stride = 10'd1;
                tw_if.bst_len    = 11'd4;
            end else begin
                tw_if.bst_start = 1'b0;
            end
            @(negedge clk);
            if (tw_if.busy) begin
                busy_cnt++;
                chk("t3_in_ready_busy", 64'(tw_if.in_ready), 64'd0);
            end
            @(posedge clk); #1;
        end
        chk("t3_busy_cycles", 64'(busy_cnt), 64'd4);

        // Zero-length burst is a no-op.
        start_burst(10'd5, 10'd1, 11'd0);
        @(negedge clk);
        chk("len0_busy", 64'(tw_if.busy), 64'd0);
        idle_cycles(5);

        // Back-pressure during a burst.
        n0 = n_out;
        for (int unsigned i = 0; i < 8; i++) exp_q.push_back(t4_w[i]);
        start_burst(10'd0, 10'd128, 11'd8);
        for (int unsigned c = 0; c < 80 && (n_out - n0) < 8; c++) begin
            tw_if.out_ready = pat[c % 4];
            @(posedge clk); #1;
        end
        tw_if.out_ready = 1'b1;
        idle_cycles(6);
        chk("t4_out_count", 64'(n_out - n0), 64'd8);

        // Reset in the middle of a burst.
        n0 = n_out;
        for (int unsigned i = 0; i < 8; i++) exp_q.push_back(t1_w[i % 4]);
        start_burst(10'd0, 10'd256, 11'd8);
        guard = 0;
        while ((n_out - n0) < 2 && guard < 30) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("t5_reached_elem3", 64'(n_out - n0), 64'd2);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_rst_out_valid", 64'(tw_if.out_valid), 64'd0);
        chk("t5_rst_busy", 64'(tw_if.busy), 64'd0);
        @(posedge clk); #1;
        send_direct(10'd0, 32'h7FFF0000, 1'b0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!tw_if.out_valid && lat < 10);
        chk("t5_latency", 64'(lat), 64'd3);
        @(posedge clk); #1;
        idle_cycles(5);

`ifdef TWIDDLE_IFFT_EN
        send_direct(10'd256, 32'h00007FFF, 1'b1);
        send_direct(10'd256, 32'h00008001, 1'b0);
        exp_q.push_back(32'h5A825A82);
        exp_q.push_back(32'h7FFF0000);
        tw_if.inv = 1'b1;
        start_burst(10'd128, 10'd896, 11'd2);
        tw_if.inv = 1'b0;
        idle_cycles(8);
`endif

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
